// File: rtl/dm_byte_lane_memory_pkg.sv
// Shared lane-mask constants, FSM encoding and mask helpers for the MEM-stage data memory.
package dm_byte_lane_memory_pkg;

  // Lane masks emitted by the EX/MEM controller.
  localparam logic [3:0] MaskB0  = 4'b0001;
  localparam logic [3:0] MaskB1  = 4'b0010;
  localparam logic [3:0] MaskB2  = 4'b0100;
  localparam logic [3:0] MaskB3  = 4'b1000;
  localparam logic [3:0] MaskHlo = 4'b0011;
  localparam logic [3:0] MaskHhi = 4'b1100;
  localparam logic [3:0] MaskW   = 4'b1111;

  typedef enum logic {
    DmClear,
    DmReady
  } dm_state_e;

  // A mask is legal only if it is one of the seven shapes and agrees with the byte offset.
  function automatic logic mask_legal(input logic [3:0] mask, input logic [1:0] lo);
    logic ok;
    case (mask)
      MaskB0:  ok = (lo == 2'd0);
      MaskB1:  ok = (lo == 2'd1);
      MaskB2:  ok = (lo == 2'd2);
      MaskB3:  ok = (lo == 2'd3);
      MaskHlo: ok = ~lo[1];
      MaskHhi: ok = lo[1];
      MaskW:   ok = (lo == 2'd0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Spread low-aligned store data across all lanes so any strobe picks the right bits.
  function automatic logic [31:0] lane_data(input logic [3:0] mask, input logic [31:0] wdata);
    logic [31:0] d;
    case (mask)
      MaskB0, MaskB1, MaskB2, MaskB3: d = {4{wdata[7:0]}};
      MaskHlo, MaskHhi:               d = {2{wdata[15:0]}};
      default:                        d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dm_load_extend.sv
// Combinational load-lane extractor: shifts the masked lanes to bit 0 and sign/zero-extends.
module dm_load_extend
  import dm_byte_lane_memory_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [3:0]  mask_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lanes, then extend according to the access size.
  always_comb begin
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    data_o   = 32'h0;
    case (mask_i)
      MaskB0:  byte_sel = word_i[7:0];
      MaskB1:  byte_sel = word_i[15:8];
      MaskB2:  byte_sel = word_i[23:16];
      MaskB3:  byte_sel = word_i[31:24];
      MaskHlo: half_sel = word_i[15:0];
      MaskHhi: half_sel = word_i[31:16];
      default: ;
    endcase
    case (mask_i)
      MaskB0, MaskB1, MaskB2, MaskB3: data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      MaskHlo, MaskHhi:               data_o = {{16{signed_i & half_sel[15]}}, half_sel};
      MaskW:                          data_o = word_i;
      default:                        data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/dm_byte_lane_memory.sv
// MEM-stage data memory with lane-masked stores, extended loads and a post-reset clear sweep.
module dm_byte_lane_memory
  import dm_byte_lane_memory_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  mem_write,
  input  logic [3:0]  mem_read,
  input  logic        load_signed,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        busy,
  output logic        access_err
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  dm_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  err_q, err_d;

  logic [31:0] mem_q [Depth];

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [3:0]            mem_wstrb;
  logic [31:0]           mem_wdata;

  logic [31:0]           offset;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  in_range;
  logic                  is_write, is_read;
  logic [3:0]            req_mask;
  logic                  req_err;
  logic [31:0]           load_data;

  // Address decode and request legality.
  always_comb begin
    offset   = addr - BASE_ADDR;
    word_idx = offset[ADDR_WIDTH+1:2];
    // Below base wraps offset high, so the upper-bits test catches both ends.
    in_range = (addr >= BASE_ADDR) && ((offset >> (ADDR_WIDTH + 2)) == 32'h0);
    is_write = |mem_write;
    is_read  = |mem_read;
    req_mask = is_write ? mem_write : mem_read;
    req_err  = (is_write && is_read) || !mask_legal(req_mask, addr[1:0]) || !in_range;
  end

  dm_load_extend u_load_extend (
    .word_i   (mem_q[word_idx]),
    .mask_i   (mem_read),
    .signed_i (load_signed),
    .data_o   (load_data)
  );

  // Clear FSM, access dispatch and next-state of the WB-facing registers.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wstrb = 4'h0;
    mem_wdata = 32'h0;
    case (state_q)
      DmClear: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wstrb = 4'hf;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) begin
          state_d = DmReady;
        end
      end
      DmReady: begin
        if (is_write || is_read) begin
          if (req_err) begin
            err_d = 1'b1;
          end else if (is_write) begin
            mem_we    = 1'b1;
            mem_waddr = word_idx;
            mem_wstrb = mem_write;
            mem_wdata = lane_data(mem_write, wdata);
          end else begin
            rdata_d  = load_data;
            rvalid_d = 1'b1;
          end
        end
      end
      default: state_d = DmClear;
    endcase
  end

  // Control and output registers; reset restarts the clear sweep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= DmClear;
      clr_cnt_q <= '0;
      rdata_q   <= 32'h0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
    end
  end

  // Byte-strobed array write; contents are initialised by the clear sweep, not by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_wstrb[i]) begin
          mem_q[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata      = rdata_q;
  assign rvalid     = rvalid_q;
  assign access_err = err_q;
  assign busy       = (state_q == DmClear);

endmodule

// File: tb/tb_dm_byte_lane_memory.sv
// Directed bench for dm_byte_lane_memory with hand-computed expectations.
module tb_dm_byte_lane_memory;

  localparam int Depth = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  mem_write = 4'h0;
  logic [3:0]  mem_read = 4'h0;
  logic        load_signed = 1'b0;
  logic [31:0] rdata;
  logic        rvalid;
  logic        busy;
  logic        access_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dm_byte_lane_memory #(
    .ADDR_WIDTH (12),
    .BASE_ADDR  (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .addr        (addr),
    .wdata       (wdata),
    .mem_write   (mem_write),
    .mem_read    (mem_read),
    .load_signed (load_signed),
    .rdata       (rdata),
    .rvalid      (rvalid),
    .busy        (busy),
    .access_err  (access_err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", tag, act, exp);
    end
  endtask

  // One request for one cycle; outputs are sampled just after the edge that consumed it.
  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] mw,
                     input logic [3:0] mr, input logic sgn);
    @(negedge clk);
    addr = a; wdata = d; mem_write = mw; mem_read = mr; load_signed = sgn;
    @(posedge clk);
    #1;
    mem_write = 4'h0; mem_read = 4'h0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  // Count edges until busy drops; also note any rvalid seen meanwhile.
  task automatic count_busy(output int n, output logic saw_rv);
    n = 0;
    saw_rv = 1'b0;
    while (busy && n < 2 * Depth + 16) begin
      @(posedge clk);
      #1;
      n++;
      if (rvalid) saw_rv = 1'b1;
    end
  endtask

  int   nb;
  logic rv_seen;

  initial begin
    #3;
    check("reset_rdata", rdata, 32'h0);
    check("reset_rvalid", {31'h0, rvalid}, 32'h0);
    check("reset_err", {31'h0, access_err}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h1);

    @(negedge clk);
    reset = 1'b0;
    count_busy(nb, rv_seen);
    check("clear_cycles", nb, Depth);
    check("clear_no_rvalid", {31'h0, rv_seen}, 32'h0);

    req(32'h1234, 32'h0, 4'h0, 4'hf, 1'b0);
    check("lw_cleared", rdata, 32'h0);
    check("lw_cleared_rv", {31'h0, rvalid}, 32'h1);
    idle_cycle();
    check("idle_rv", {31'h0, rvalid}, 32'h0);

    // Word store then byte loads.
    req(32'h10, 32'h8899AABB, 4'hf, 4'h0, 1'b0);
    check("sw_no_rv", {31'h0, rvalid}, 32'h0);
    check("sw_no_err", {31'h0, access_err}, 32'h0);
    req(32'h11, 32'h0, 4'h0, 4'b0010, 1'b1);
    check("lb_signed", rdata, 32'hFFFFFFAA);
    check("lb_rv", {31'h0, rvalid}, 32'h1);
    req(32'h11, 32'h0, 4'h0, 4'b0010, 1'b0);
    check("lbu", rdata, 32'h000000AA);
    idle_cycle();
    check("rdata_hold", rdata, 32'h000000AA);

    // Upper half store.
    req(32'h22, 32'h00001234, 4'b1100, 4'h0, 1'b0);
    req(32'h20, 32'h0, 4'h0, 4'hf, 1'b0);
    check("sh_hi_lw", rdata, 32'h12340000);
    req(32'h22, 32'h0, 4'h0, 4'b1100, 1'b1);
    check("lh_hi", rdata, 32'h00001234);

    // Byte store into an existing word.
    req(32'h30, 32'h11223344, 4'hf, 4'h0, 1'b0);
    req(32'h33, 32'h000000F0, 4'b1000, 4'h0, 1'b0);
    req(32'h30, 32'h0, 4'h0, 4'hf, 1'b0);
    check("sb_lane3_lw", rdata, 32'hF0223344);
    req(32'h33, 32'h0, 4'h0, 4'b1000, 1'b1);
    check("lb_lane3", rdata, 32'hFFFFFFF0);
    req(32'h30, 32'h0, 4'h0, 4'b0011, 1'b1);
    check("lh_lo", rdata, 32'h00003344);

    // Error cases.
    req(32'h42, 32'h0000FFFF, 4'b0011, 4'h0, 1'b0);
    check("err_misalign", {31'h0, access_err}, 32'h1);
    check("err_misalign_rv", {31'h0, rvalid}, 32'h0);
    idle_cycle();
    check("err_pulse_end", {31'h0, access_err}, 32'h0);
    req(32'h40, 32'h0, 4'h0, 4'hf, 1'b0);
    check("err_misalign_mem", rdata, 32'h0);
    req(32'h40, 32'h0, 4'h0, 4'b0101, 1'b0);
    check("err_illegal", {31'h0, access_err}, 32'h1);
    check("err_illegal_rv", {31'h0, rvalid}, 32'h0);
    req(32'h4000, 32'h0, 4'h0, 4'hf, 1'b0);
    check("err_range", {31'h0, access_err}, 32'h1);
    req(32'h10, 32'h0, 4'hf, 4'hf, 1'b0);
    check("err_both", {31'h0, access_err}, 32'h1);
    check("err_both_rv", {31'h0, rvalid}, 32'h0);
    req(32'h10, 32'h0, 4'h0, 4'hf, 1'b0);
    check("err_both_mem", rdata, 32'h8899AABB);
    check("ok_no_err", {31'h0, access_err}, 32'h0);

    // Reset during clear with stores around it.
    req(32'h100, 32'hDEADBEEF, 4'hf, 4'h0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_busy", {31'h0, busy}, 32'h1);
    check("rst_rv", {31'h0, rvalid}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    req(32'h100, 32'h12345678, 4'hf, 4'h0, 1'b0);
    check("busy_req_ignored_err", {31'h0, access_err}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    count_busy(nb, rv_seen);
    check("reclear_cycles", nb, Depth);
    check("reclear_no_rvalid", {31'h0, rv_seen}, 32'h0);
    req(32'h100, 32'h0, 4'h0, 4'hf, 1'b0);
    check("reclear_word", rdata, 32'h0);
    req(32'h10, 32'h0, 4'h0, 4'hf, 1'b0);
    check("reclear_old_word", rdata, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
